// File: rtl/ripple_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ripple_adder_pkg
//  Description : Shared width default and result-word type for the ripple
//                adder and its bench.
//  Revision    : 1.0 - initial release
// ============================================================================
package ripple_adder_pkg;

    localparam int RIPPLE_ADDER_WIDTH_DEFAULT = 4;

    // Full result at the default width: carry-out in the MSB, sum below it.
    typedef logic [RIPPLE_ADDER_WIDTH_DEFAULT:0] ripple_result_t;

endpackage : ripple_adder_pkg
`default_nettype wire

// File: rtl/full_adder_cell.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_cell
//  Description : One-bit combinational full adder; one link of the ripple
//                carry chain.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic prop_w;

    // Propagate term is shared by the sum and the carry equations.
    always_comb begin
        prop_w = a ^ b;
        s      = prop_w ^ cin;
        cout   = (a & b) | (cin & prop_w);
    end

endmodule : full_adder_cell
`default_nettype wire

// File: rtl/ripple_adder_4bit.sv
`default_nettype none
// ============================================================================
//  Module      : ripple_adder_4bit
//  Description : Registered WIDTH-bit ripple-carry adder with carry-in.
//                {carry_out, sum} = a + b + carry_in, one cycle after the
//                operands are sampled.
//  Options     : RIPPLE_ADDER_OVF_EN - adds a registered two's-complement
//                overflow output.
//  Revision    : 1.0 - initial release
// ============================================================================
module ripple_adder_4bit
    import ripple_adder_pkg::*;
#(
    parameter int WIDTH = RIPPLE_ADDER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef RIPPLE_ADDER_OVF_EN
    ,
    output logic             overflow
`endif
);

    // carry_w[i] enters cell i; carry_w[WIDTH] leaves the top cell.
    logic [WIDTH:0]   carry_w;
    logic [WIDTH-1:0] sum_d;
    logic             carry_out_d;
    logic [WIDTH-1:0] sum_q;
    logic             carry_out_q;

    assign carry_w[0] = carry_in;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            full_adder_cell u_fa (
                .a    (a[i]),
                .b    (b[i]),
                .cin  (carry_w[i]),
                .s    (sum_d[i]),
                .cout (carry_w[i+1])
            );
        end
    endgenerate

    assign carry_out_d = carry_w[WIDTH];

    // Output register stage; reset wins over whatever the chain produced.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            carry_out_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
        end
    end

    assign sum       = sum_q;
    assign carry_out = carry_out_q;

`ifdef RIPPLE_ADDER_OVF_EN
    logic overflow_d;
    logic overflow_q;

    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign overflow_d = carry_w[WIDTH] ^ carry_w[WIDTH-1];

    // Overflow flag registered alongside the sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule : ripple_adder_4bit
`default_nettype wire

// File: tb/tb_ripple_adder_4bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ripple_adder_4bit
//  Description : Directed self-checking bench for ripple_adder_4bit.
//                Define RIPPLE_ADDER_OVF_EN to also check the overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ripple_adder_4bit;
    import ripple_adder_pkg::*;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
    logic [W-1:0] sum;
    logic         carry_out;
`ifdef RIPPLE_ADDER_OVF_EN
    logic         overflow;
`endif

    int n_vec;
    int n_err;

    ripple_adder_4bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef RIPPLE_ADDER_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset holds outputs at zero even with non-zero operands, then releases.
    task automatic test_reset();
        rst = 1'b1; a = 4'd9; b = 4'd6; carry_in = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            n_vec++;
            if ({carry_out, sum} !== 5'd0) begin
                n_err++;
                $display("FAIL reset_hold[%0d]: got %0d, want 0", k, {carry_out, sum});
            end
`ifdef RIPPLE_ADDER_OVF_EN
            n_vec++;
            if (overflow !== 1'b0) begin
                n_err++;
                $display("FAIL reset_ovf[%0d]: got %b, want 0", k, overflow);
            end
`endif
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (sum !== 4'd0 || carry_out !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: got sum=%0d cout=%b, want sum=0 cout=1", sum, carry_out);
        end
    endtask

    // Hand-computed corner vectors.
    task automatic test_corners();
        logic [W-1:0]   ta [4] = '{4'd0,  4'd15, 4'd15, 4'd8};
        logic [W-1:0]   tb [4] = '{4'd0,  4'd15, 4'd0,  4'd7};
        logic           tc [4] = '{1'b0,  1'b1,  1'b1,  1'b0};
        ripple_result_t te [4] = '{5'd0,  5'd31, 5'd16, 5'd15};
        for (int k = 0; k < 4; k++) begin
            a = ta[k]; b = tb[k]; carry_in = tc[k];
            @(posedge clk); #1;
            n_vec++;
            if ({carry_out, sum} !== te[k]) begin
                n_err++;
                $display("FAIL corner[%0d] %0d+%0d+%0d: got %0d, want %0d",
                         k, ta[k], tb[k], tc[k], {carry_out, sum}, te[k]);
            end
        end
    endtask

    // Carry-in alone ripples through every cell: 15+0+cin gives 15 / 16.
    task automatic test_ripple();
        a = 4'd15; b = 4'd0;
        for (int k = 0; k < 6; k++) begin
            carry_in = k[0];
            @(posedge clk); #1;
            n_vec++;
            if ({carry_out, sum} !== (k[0] ? 5'd16 : 5'd15)) begin
                n_err++;
                $display("FAIL ripple[%0d]: got %0d, want %0d",
                         k, {carry_out, sum}, (k[0] ? 16 : 15));
            end
        end
    endtask

    // Back-to-back exhaustive sweep with a single-cycle reset pulse inside it.
    task automatic test_sweep();
        int             idx;
        ripple_result_t exp_r;
        idx = 0;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    a = ai[W-1:0]; b = bi[W-1:0]; carry_in = ci[0];
                    rst = (idx == 200);
                    exp_r = rst ? 5'd0 : ripple_result_t'(ai + bi + ci);
                    @(posedge clk); #1;
                    n_vec++;
                    if ({carry_out, sum} !== exp_r) begin
                        n_err++;
                        $display("FAIL sweep %0d+%0d+%0d rst=%b: got %0d, want %0d",
                                 ai, bi, ci, rst, {carry_out, sum}, exp_r);
                    end
`ifdef RIPPLE_ADDER_OVF_EN
                    begin
                        logic exp_o;
                        exp_o = !rst && (a[W-1] == b[W-1]) && (exp_r[W-1] != a[W-1]);
                        n_vec++;
                        if (overflow !== exp_o) begin
                            n_err++;
                            $display("FAIL sweep_ovf %0d+%0d+%0d: got %b, want %b",
                                     ai, bi, ci, overflow, exp_o);
                        end
                    end
`endif
                    idx++;
                end
            end
        end
        rst = 1'b0;
    endtask

`ifdef RIPPLE_ADDER_OVF_EN
    // Signed-overflow corner vectors.
    task automatic test_overflow();
        logic [W-1:0]   ta [3] = '{4'd7, 4'd8, 4'd15};
        logic [W-1:0]   tb [3] = '{4'd1, 4'd8, 4'd1};
        ripple_result_t te [3] = '{5'd8, 5'd16, 5'd16};
        logic           to [3] = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            a = ta[k]; b = tb[k]; carry_in = 1'b0;
            @(posedge clk); #1;
            n_vec++;
            if (overflow !== to[k] || {carry_out, sum} !== te[k]) begin
                n_err++;
                $display("FAIL ovf[%0d] %0d+%0d: got ovf=%b res=%0d, want ovf=%b res=%0d",
                         k, ta[k], tb[k], overflow, {carry_out, sum}, to[k], te[k]);
            end
        end
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; a = '0; b = '0; carry_in = 1'b0;
        test_reset();
        test_corners();
        test_ripple();
        test_sweep();
`ifdef RIPPLE_ADDER_OVF_EN
        test_overflow();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ripple_adder_4bit
`default_nettype wire
